// File: rtl/fp_minmax_acc.sv
// Running max/min/count of a burst using one shared external FP comparator; each element after the first costs 1 accept cycle plus 1 or 2 compares of CMP_LAT+1 cycles.
// The input stalls during compares and the result is held until out_ready; FP_MINMAX_IDX_EN adds first-occurrence index outputs.
module fp_minmax_acc #(
  parameter int W       = 32,
  parameter int CMP_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [W-1:0]     cmp_in1,
  output logic [W-1:0]     cmp_in2,
  output logic             cmp_act,
  input  logic             cmp_eq,
  input  logic             cmp_great,
  input  logic             cmp_less,
  input  logic             cmp_done,
  input  logic             cmp_inv,
  output logic [W-1:0]     out_max,
  output logic [W-1:0]     out_min,
  output logic [CNT_W-1:0] out_count,
  output logic             out_inv,
`ifdef FP_MINMAX_IDX_EN
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int WW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
  localparam logic [WW-1:0]    LAT_V   = WW'(CMP_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCEPT  = 3'd1;
  localparam logic [2:0] S_CMP_MAX = 3'd2;
  localparam logic [2:0] S_CMP_MIN = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_nxt;
  logic             r_in_rdy;
  logic [WW-1:0]    r_wait;
  logic [W-1:0]     r_cmp_in1;
  logic [W-1:0]     r_cmp_in2;
  logic [W-1:0]     r_max;
  logic [W-1:0]     r_min;
  logic [CNT_W-1:0] r_count;
  logic             r_inv;
  logic             r_last;
`ifdef FP_MINMAX_IDX_EN
  logic [CNT_W-1:0] r_x_idx;
  logic [CNT_W-1:0] r_max_idx;
  logic [CNT_W-1:0] r_min_idx;
`endif

  logic       w_in_hs;
  logic       w_cmp;
  logic       w_sample;
  logic       w_bad;
  logic [2:0] w_fin;

  assign w_in_hs  = in_valid & r_in_rdy;
  assign w_cmp    = (r_state == S_CMP_MAX) || (r_state == S_CMP_MIN);
  assign w_sample = w_cmp && (r_wait == LAT_V);
  // A missing done is as untrustworthy as an exception; a signed-zero pair (inv with eq) is a plain tie.
  assign w_bad    = !cmp_done || (cmp_inv && !cmp_eq);
  assign w_fin    = r_last ? S_DONE : S_ACCEPT;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_in_hs) w_nxt = in_last ? S_DONE : S_ACCEPT;
      S_ACCEPT:  if (w_in_hs) w_nxt = S_CMP_MAX;
      S_CMP_MAX: if (w_sample) w_nxt = (w_bad || cmp_great) ? w_fin : S_CMP_MIN;
      S_CMP_MIN: if (w_sample) w_nxt = w_fin;
      S_DONE:    if (out_ready) w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_in_rdy  <= 1'b0;
      r_wait    <= '0;
      r_cmp_in1 <= '0;
      r_cmp_in2 <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_count   <= '0;
      r_inv     <= 1'b0;
      r_last    <= 1'b0;
`ifdef FP_MINMAX_IDX_EN
      r_x_idx   <= '0;
      r_max_idx <= '0;
      r_min_idx <= '0;
`endif
    end else begin
      r_state  <= w_nxt;
      r_in_rdy <= (w_nxt == S_IDLE) || (w_nxt == S_ACCEPT);
      r_wait   <= (w_cmp && !w_sample) ? r_wait + WW'(1) : '0;
      case (r_state)
        S_IDLE: if (w_in_hs) begin
          r_max   <= in_data;
          r_min   <= in_data;
          r_count <= CNT_W'(1);
          r_inv   <= 1'b0;
`ifdef FP_MINMAX_IDX_EN
          r_max_idx <= '0;
          r_min_idx <= '0;
`endif
        end
        S_ACCEPT: if (w_in_hs) begin
          r_cmp_in1 <= in_data;
          r_cmp_in2 <= r_max;
          r_last    <= in_last;
          if (r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
`ifdef FP_MINMAX_IDX_EN
          r_x_idx <= r_count;
`endif
        end
        S_CMP_MAX: if (w_sample) begin
          if (w_bad) r_inv <= 1'b1;
          else if (cmp_great) begin
            r_max <= r_cmp_in1;
`ifdef FP_MINMAX_IDX_EN
            r_max_idx <= r_x_idx;
`endif
          end else r_cmp_in2 <= r_min;
        end
        S_CMP_MIN: if (w_sample) begin
          if (w_bad) r_inv <= 1'b1;
          else if (cmp_less) begin
            r_min <= r_cmp_in1;
`ifdef FP_MINMAX_IDX_EN
            r_min_idx <= r_x_idx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_rdy;
  assign cmp_in1   = r_cmp_in1;
  assign cmp_in2   = r_cmp_in2;
  assign cmp_act   = w_cmp;
  assign out_max   = r_max;
  assign out_min   = r_min;
  assign out_count = r_count;
  assign out_inv   = r_inv;
  assign out_valid = (r_state == S_DONE);
`ifdef FP_MINMAX_IDX_EN
  assign out_max_idx = r_max_idx;
  assign out_min_idx = r_min_idx;
`endif

endmodule

// File: tb/tb_fp_minmax_acc.sv
// Bench for fp_minmax_acc: models the external comparator and checks each burst against an ordering-based reference.
module tb_fp_minmax_acc;
  localparam int W       = 32;
  localparam int CMP_LAT = 2;
  localparam int CNT_W   = 4;
  localparam int SAT     = (1 << CNT_W) - 1;

  typedef struct packed {logic inv; logic eq; logic gt; logic lt;} cmp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, cmp_act, out_inv, out_valid;
  logic [W-1:0] cmp_in1, cmp_in2, out_max, out_min;
  logic [CNT_W-1:0] out_count;
  logic cmp_eq, cmp_great, cmp_less, cmp_done, cmp_inv;
`ifdef FP_MINMAX_IDX_EN
  logic [CNT_W-1:0] out_max_idx, out_min_idx;
`endif

  always #5 clk = ~clk;

  fp_minmax_acc #(.W(W), .CMP_LAT(CMP_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .cmp_in1(cmp_in1), .cmp_in2(cmp_in2), .cmp_act(cmp_act),
    .cmp_eq(cmp_eq), .cmp_great(cmp_great), .cmp_less(cmp_less), .cmp_done(cmp_done),
    .cmp_inv(cmp_inv), .out_max(out_max), .out_min(out_min), .out_count(out_count),
    .out_inv(out_inv),
`ifdef FP_MINMAX_IDX_EN
    .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
`endif
    .out_valid(out_valid), .out_ready(out_ready));

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 0);
  endfunction
  function automatic logic is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 0);
  endfunction

  // IEEE ordering via sign-magnitude keys; flags inv for NaN, Inf and a +0/-0 pair.
  function automatic cmp_t fcmp(input logic [31:0] a, input logic [31:0] b);
    cmp_t r;
    logic [31:0] ka, kb;
    r = '0;
    if (is_nan(a) || is_nan(b)) r.inv = 1'b1;
    else if (a[30:0] == 0 && b[30:0] == 0) begin
      r.eq = 1'b1;
      r.inv = a[31] ^ b[31];
    end else begin
      ka = a[31] ? ~a : {1'b1, a[30:0]};
      kb = b[31] ? ~b : {1'b1, b[30:0]};
      r.eq = (ka == kb);
      r.gt = (ka > kb);
      r.lt = (ka < kb);
      r.inv = is_inf(a) || is_inf(b);
    end
    return r;
  endfunction

  // Comparator model: results valid once operands have been stable CMP_LAT cycles.
  logic drop_done = 1'b0;
  logic p_act = 1'b0;
  logic [W-1:0] p1 = '0, p2 = '0;
  int stab = 0;
  int act_cyc = 0;
  cmp_t w_res;

  always @(posedge clk) begin
    if (cmp_act && p_act && cmp_in1 == p1 && cmp_in2 == p2) stab <= (stab < 100) ? stab + 1 : stab;
    else stab <= cmp_act ? 1 : 0;
    p_act <= cmp_act;
    p1 <= cmp_in1;
    p2 <= cmp_in2;
    if (cmp_act) act_cyc <= act_cyc + 1;
  end

  assign w_res     = fcmp(cmp_in1, cmp_in2);
  assign cmp_done  = cmp_act && (stab >= CMP_LAT) && !drop_done;
  assign cmp_eq    = cmp_done & w_res.eq;
  assign cmp_great = cmp_done & w_res.gt;
  assign cmp_less  = cmp_done & w_res.lt;
  assign cmp_inv   = cmp_done & w_res.inv;

  int checks = 0;
  int errors = 0;
  logic [31:0] bq[$];
  logic [31:0] e_max, e_min;
  int e_cnt, e_phase, e_maxi, e_mini;
  logic e_inv;

  task automatic model();
    cmp_t r;
    logic [31:0] x;
    e_max = bq[0]; e_min = bq[0]; e_inv = 1'b0; e_phase = 0; e_maxi = 0; e_mini = 0;
    for (int i = 1; i < bq.size(); i++) begin
      x = bq[i];
      r = fcmp(x, e_max);
      e_phase++;
      if (drop_done || (r.inv && !r.eq)) e_inv = 1'b1;
      else if (r.gt) begin e_max = x; e_maxi = (i < SAT) ? i : SAT; end
      else begin
        r = fcmp(x, e_min);
        e_phase++;
        if (drop_done || (r.inv && !r.eq)) e_inv = 1'b1;
        else if (r.lt) begin e_min = x; e_mini = (i < SAT) ? i : SAT; end
      end
    end
    e_cnt = (bq.size() < SAT) ? bq.size() : SAT;
  endtask

  task automatic send_elem(input logic [31:0] d, input logic l, output bit ok);
    int n;
    in_data = d; in_last = l; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    ok = in_ready;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got in_ready=%b want 1 within 200 cycles", in_ready);
    end else @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_burst(input string nm, input int gap_max, input int hold, input bit single);
    int a0, n;
    bit ok;
    model();
    a0 = act_cyc;
    for (int i = 0; i < bq.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_elem(bq[i], i == bq.size() - 1, ok);
      if (!ok) return;
    end
    if (single) begin
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL %s single_latency: out_valid=%b want 1", nm, out_valid); end
    end
    n = 0;
    while (!out_valid && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid_timeout: got %b want 1", nm, out_valid); return; end
    checks += 5;
    if (out_max !== e_max) begin errors++; $display("FAIL %s max: got %h want %h", nm, out_max, e_max); end
    if (out_min !== e_min) begin errors++; $display("FAIL %s min: got %h want %h", nm, out_min, e_min); end
    if (out_count !== CNT_W'(e_cnt)) begin errors++; $display("FAIL %s count: got %0d want %0d", nm, out_count, e_cnt); end
    if (out_inv !== e_inv) begin errors++; $display("FAIL %s inv: got %b want %b", nm, out_inv, e_inv); end
    if (act_cyc - a0 != e_phase * (CMP_LAT + 1)) begin
      errors++; $display("FAIL %s cmp_act_cycles: got %0d want %0d", nm, act_cyc - a0, e_phase * (CMP_LAT + 1));
    end
`ifdef FP_MINMAX_IDX_EN
    checks += 2;
    if (out_max_idx !== CNT_W'(e_maxi)) begin errors++; $display("FAIL %s max_idx: got %0d want %0d", nm, out_max_idx, e_maxi); end
    if (out_min_idx !== CNT_W'(e_mini)) begin errors++; $display("FAIL %s min_idx: got %0d want %0d", nm, out_min_idx, e_mini); end
`endif
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== e_max || out_min !== e_min || out_count !== CNT_W'(e_cnt))
      begin
        errors++;
        $display("FAIL %s hold_stable: cycle %0d valid=%b rdy=%b max=%h min=%h cnt=%0d want 1/0/%h/%h/%0d",
                 nm, c, out_valid, in_ready, out_max, out_min, out_count, e_max, e_min, e_cnt);
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s release: valid=%b in_ready=%b want 0/1", nm, out_valid, in_ready);
    end
  endtask

  function automatic logic [31:0] rnd_val(input logic [31:0] prev);
    int s;
    logic sg;
    s = $urandom_range(0, 15);
    sg = 1'($urandom_range(0, 1));
    if (s < 11) return {sg, 8'($urandom_range(120, 134)), 23'($urandom)};
    else if (s < 13) return prev;
    else if (s == 13) return {sg, 31'h0};
    else if (s == 14) return {sg, 8'hFF, 23'h0};
    else return {sg, 8'hFF, 23'($urandom) | 23'h1};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0 || cmp_act !== 1'b0) begin errors++; $display("FAIL reset ctrl: valid=%b act=%b want 0/0", out_valid, cmp_act); end
    if (out_max !== 0 || out_min !== 0) begin errors++; $display("FAIL reset data: max=%h min=%h want 0", out_max, out_min); end
    if (out_count !== 0 || out_inv !== 0) begin errors++; $display("FAIL reset cnt: cnt=%0d inv=%b want 0", out_count, out_inv); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset release in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    bq = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000}; run_burst("mixed", 0, 0, 0);
    bq = '{32'h3F800000};                                            run_burst("single", 0, 0, 1);
    bq = '{32'h3F800000, 32'h3F800000};                              run_burst("tie", 0, 0, 0);
    bq = '{32'h3F800000, 32'h7F800000};                              run_burst("inf", 0, 0, 0);
    bq = '{32'h80000000, 32'h00000000};                              run_burst("signed_zero", 0, 0, 0);
    bq.delete();
    for (int i = 0; i < 17; i++) bq.push_back(32'h3F800000 + 32'(i) * 32'h00100000);
    run_burst("saturate", 0, 0, 0);
  endtask

  task automatic test_done_drop();
    drop_done = 1'b1;
    bq = '{32'h3F800000, 32'h40000000, 32'hBF800000};
    run_burst("no_done", 0, 0, 0);
    drop_done = 1'b0;
  endtask

  task automatic test_backpressure();
    bq = '{32'h40400000, 32'hC1000000, 32'h41000000};
    run_burst("backpressure", 1, 10, 0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    send_elem(32'h3F800000, 1'b0, ok);
    send_elem(32'h40000000, 1'b0, ok);
    n = 0;
    while (!cmp_act && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cmp_act !== 1'b1) begin errors++; $display("FAIL mid_reset cmp_act_start: got %b want 1", cmp_act); end
    rst = 1'b0;
    #1;
    checks += 3;
    if (cmp_act !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset ctrl: act=%b valid=%b rdy=%b want 0/0/0", cmp_act, out_valid, in_ready);
    end
    if (out_max !== 0 || out_min !== 0 || cmp_in1 !== 0 || cmp_in2 !== 0) begin
      errors++; $display("FAIL mid_reset data: max=%h min=%h in1=%h in2=%h want 0", out_max, out_min, cmp_in1, cmp_in2);
    end
    if (out_count !== 0 || out_inv !== 0) begin errors++; $display("FAIL mid_reset cnt: cnt=%0d inv=%b want 0", out_count, out_inv); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bq = '{32'h40000000};
    run_burst("after_reset", 0, 0, 1);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int b = 0; b < 30; b++) begin
      bq.delete();
      v = 32'h3F800000;
      for (int i = 0; i < $urandom_range(1, 20); i++) begin
        v = rnd_val(v);
        bq.push_back(v);
      end
      run_burst("random", 2, $urandom_range(0, 3), 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++) begin
      bq = '{32'(b) << 20 | 32'h41000000, 32'hC2000000, 32'h42800000};
      run_burst("back_to_back", 0, 0, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_done_drop();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_minmax_acc.md
Name: fp_minmax_acc

Overview:
- Downstream consumer of the FP comparator (eq/great/less/done/inv).
- Accepts a burst of IEEE-754 single-precision values over a valid/ready stream.
- Drives one shared external comparator to track the running maximum and minimum.
- Returns max, min, element count and a sticky invalid flag through a valid/ready result port.

Parameters:
W, 32, operand width in bits (fixed single precision).
CMP_LAT, 2, comparator latency in cycles from stable cmp_in1/cmp_in2 to valid cmp_* results.
CNT_W, 16, element counter width.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
in_data  input  W  operand
in_valid  input  1  operand valid
in_last  input  1  marks final operand of burst
in_ready  output  1  block can accept operand
cmp_in1  output  W  comparator operand 1 (new value)
cmp_in2  output  W  comparator operand 2 (current max or min)
cmp_act  output  1  comparison request, high throughout each compare
cmp_eq  input  1  comparator equal
cmp_great  input  1  comparator in1 > in2
cmp_less  input  1  comparator in1 < in2
cmp_done  input  1  comparator result valid
cmp_inv  input  1  comparator exception (NaN/Inf/signed zero)
out_max  output  W  burst maximum
out_min  output  W  burst minimum
out_count  output  CNT_W  elements in burst
out_inv  output  1  sticky: any compare reported invalid
out_valid  output  1  result valid
out_ready  input  1  result consumer ready

Behaviour:
Reset:
- Asynchronous, active-low on rst; clock clk.
- State returns to IDLE; all outputs and internal registers go to 0.
- in_ready = 0 while rst is low.
- Reset mid-burst or mid-compare discards all partial results.

States:
- IDLE: in_ready=1. On in_valid&in_ready, load max=min=in_data, count=1, inv=0. Go to DONE if in_last, else to ACCEPT. No comparison is issued for the first element.
- ACCEPT: in_ready=1. On handshake, latch x=in_data and last=in_last, saturating-increment count, then go to CMP_MAX.
- CMP_MAX: in_ready=0, cmp_act=1, cmp_in1=x, cmp_in2=max, held stable. Wait counter runs 0..CMP_LAT; sample cmp_* when counter==CMP_LAT, so the state lasts CMP_LAT+1 cycles.
  - If cmp_done&cmp_inv&!cmp_eq: set inv, no update.
  - Else if cmp_great: max=x, skip CMP_MIN.
  - Else go to CMP_MIN.
- CMP_MIN: same timing, cmp_in2=min.
  - If cmp_done&cmp_inv&!cmp_eq: set inv.
  - Else if cmp_less: min=x.
- After a compare completes: go to DONE if last, else ACCEPT.
- DONE: out_valid=1; out_max/out_min/out_count/out_inv registered and stable. On out_ready, go to IDLE (in_ready=1 next cycle). out_valid deasserts the cycle after the handshake.

Rules:
- cmp_act=0 and cmp_in1/cmp_in2 hold their last value outside CMP states.
- Ties (cmp_eq) never update, so the first occurrence is retained.
- Signed-zero pair (cmp_inv&cmp_eq) is treated as equal and does not set inv.
- If cmp_done=0 at the sample point: treat as invalid (set inv, no update).
- count saturates at 2^CNT_W-1 and does not wrap.
- Per-element cost after the first: 1 accept cycle + (CMP_LAT+1) or 2*(CMP_LAT+1) compare cycles.

Optional Feature:
- Macro: FP_MINMAX_IDX_EN.
- Defined: adds out_max_idx and out_min_idx outputs (CNT_W, reset 0). Each holds the 0-based burst index of the first occurrence of the max/min, updated alongside max/min.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Burst 3F800000, 40000000, C0400000, 3F000000 (last) -> out_max=40000000, out_min=C0400000, out_count=4, out_inv=0; with IDX_EN, max_idx=1, min_idx=2.
- Single element 3F800000 with in_last -> out_valid 1 cycle after accept; max=min=3F800000, count=1, cmp_act never asserted.
- Burst 3F800000, 3F800000 (last) -> no update; max=min=3F800000, count=2; with IDX_EN, both idx=0; exactly one CMP_MAX and one CMP_MIN of CMP_LAT+1 cycles each.
- Burst 3F800000, 7F800000 (last) -> cmp_inv seen; out_inv=1, max=min=3F800000.
- out_ready held 0 for 10 cycles in DONE -> out_valid=1, outputs stable, in_ready=0; on release, in_ready=1 the next cycle.
- rst pulled low during CMP_MAX of element 2 -> all outputs 0 immediately, cmp_act=0; after release, new burst 40000000 (last) -> max=min=40000000, count=1.
